// File: rtl/bp_fe_mock_be_pkg.sv
// Shared FE/BE interface types for the mock backend: command and queue
// packet layouts, their opcode/message enums, and the processor config widths.
package bp_fe_mock_be_pkg;

    // Processor config slice used by the FE/BE interface
    localparam int vaddr_width_gp               = 39;
    localparam int branch_metadata_fwd_width_gp = 8;

    localparam logic [vaddr_width_gp-1:0] dram_base_addr_gp = 39'h00_8000_0000;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_icache_fence         = 3'd3
    } bp_fe_command_queue_opcode_e;

    typedef enum logic [1:0] {
        e_subop_follow            = 2'd0,
        e_subop_branch_mispredict = 2'd1,
        e_subop_trap              = 2'd2,
        e_subop_context_switch    = 2'd3
    } bp_fe_command_queue_subopcode_e;

    typedef enum logic {
        e_fe_fetch     = 1'b0,
        e_fe_exception = 1'b1
    } bp_fe_queue_type_e;

    typedef struct packed {
        bp_fe_command_queue_opcode_e           opcode;
        bp_fe_command_queue_subopcode_e        subopcode;
        logic [vaddr_width_gp-1:0]             vaddr;
        logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
    } bp_fe_cmd_s;

    typedef struct packed {
        bp_fe_queue_type_e         msg_type;
        logic [vaddr_width_gp-1:0] pc;
        logic [31:0]               instr;
    } bp_fe_queue_s;

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == '1) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/bp_fe_mock_be_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) stepping every cycle; bit0 is
// used as a pseudo-random stall request for queue backpressure.
module bp_fe_mock_be_lfsr
    #(parameter logic [7:0] seed_p = 8'h5A)
    (
        input  logic clk_i,
        input  logic reset_i,
        output logic stall_o
    );

    logic [7:0] lfsr_q, lfsr_d;

    // Next LFSR value: shift left, feed back the tap XOR
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR state register, reseeded on reset
    always_ff @(posedge clk_i) begin
        if (reset_i) lfsr_q <= seed_p;
        else         lfsr_q <= lfsr_d;
    end

    assign stall_o = lfsr_q[0];

endmodule

// File: rtl/bp_fe_mock_be.sv
// Mock backend for FE-only benches: boots the FE with a state reset, checks
// that accepted fetch PCs advance by 4, periodically redirects the FE and
// squashes stale packets, and exposes sticky done/error flags.
module bp_fe_mock_be
    import bp_fe_mock_be_pkg::*;
    #(
        parameter logic [vaddr_width_gp-1:0] boot_pc_p = dram_base_addr_gp,
        parameter int redirect_interval_p = 0,
        parameter int redirect_offset_p   = 'h40,
        parameter int max_instr_p         = 1024,
        parameter bit stall_en_p          = 1'b0
    )
    (
        input  logic         clk_i,
        input  logic         reset_i,

        output bp_fe_cmd_s   fe_cmd_o,
        output logic         fe_cmd_v_o,
        input  logic         fe_cmd_yumi_i,

        input  bp_fe_queue_s fe_queue_i,
        input  logic         fe_queue_v_i,
        output logic         fe_queue_ready_o,

        output logic [31:0]  instr_count_o,
        output logic         done_o,
        output logic         error_o
    );

    typedef enum logic [2:0] {
        e_reset,
        e_send_reset,
        e_run,
        e_send_redirect,
        e_squash,
        e_done
    } state_e;

    localparam int since_w_lp = (redirect_interval_p > 0) ? $clog2(redirect_interval_p + 1) : 1;
    localparam logic [since_w_lp-1:0]     interval_lp = since_w_lp'(redirect_interval_p);
    localparam logic [vaddr_width_gp-1:0] offset_lp   = vaddr_width_gp'(redirect_offset_p);
    localparam logic [31:0]               max_lp      = 32'(max_instr_p);

    state_e                    state_q, state_d;
    logic [vaddr_width_gp-1:0] exp_pc_q, exp_pc_d;
    logic [vaddr_width_gp-1:0] target_q, target_d;
    logic [31:0]               count_q, count_d;
    logic [since_w_lp-1:0]     since_q, since_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic                      cmd_v_q, cmd_v_d;
    bp_fe_cmd_s                cmd_q, cmd_d;

    logic stall;
    logic xfer;
    logic pc_hit;

    // Instruction payload is not checked by the mock
    logic unused_instr;
    assign unused_instr = ^fe_queue_i.instr;

    if (stall_en_p) begin : g_stall
        bp_fe_mock_be_lfsr #(.seed_p(8'h5A)) u_lfsr (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .stall_o (stall)
        );
    end else begin : g_no_stall
        assign stall = 1'b0;
    end

    // Ready is a pure function of flops, so it never sees the FE's valid
    assign fe_queue_ready_o = ((state_q == e_run) || (state_q == e_squash)) && !stall;

    // Next-state, check/counter updates, and the next command to present
    always_comb begin
        state_d  = state_q;
        exp_pc_d = exp_pc_q;
        target_d = target_q;
        count_d  = count_q;
        since_d  = since_q;
        done_d   = done_q;
        error_d  = error_q;
        cmd_v_d  = 1'b0;
        cmd_d    = '0;

        xfer   = fe_queue_v_i && fe_queue_ready_o;
        pc_hit = (fe_queue_i.pc == exp_pc_q);

        case (state_q)
            e_reset: state_d = e_send_reset;

            e_send_reset: if (fe_cmd_yumi_i) begin
                exp_pc_d = boot_pc_p;
                state_d  = e_run;
            end

            // While squashing, only a packet at the redirect target is looked at;
            // once one is, checking proceeds exactly as in run.
            e_run, e_squash: if (xfer && ((state_q == e_run) || pc_hit)) begin
                state_d = e_run;
                if ((fe_queue_i.msg_type == e_fe_exception) || !pc_hit) begin
                    error_d = 1'b1;
                    state_d = e_done;
                end else begin
                    count_d  = sat_inc32(count_q);
                    exp_pc_d = exp_pc_q + vaddr_width_gp'(4);
                    since_d  = since_q + since_w_lp'(1);
                    if (count_d == max_lp) begin
                        done_d  = 1'b1;
                        state_d = e_done;
                    end else if ((redirect_interval_p != 0) && (since_d == interval_lp)) begin
                        since_d  = '0;
                        target_d = exp_pc_d + offset_lp;
                        state_d  = e_send_redirect;
                    end
                end
            end

            e_send_redirect: if (fe_cmd_yumi_i) begin
                exp_pc_d = target_q;
                state_d  = e_squash;
            end

            e_done: state_d = e_done;

            default: state_d = e_reset;
        endcase

        // Command flops load from the next state so they hold steady until yumi
        if (state_d == e_send_reset) begin
            cmd_v_d      = 1'b1;
            cmd_d.opcode = e_op_state_reset;
            cmd_d.vaddr  = boot_pc_p;
        end else if (state_d == e_send_redirect) begin
            cmd_v_d         = 1'b1;
            cmd_d.opcode    = e_op_pc_redirection;
            cmd_d.subopcode = e_subop_branch_mispredict;
            cmd_d.vaddr     = target_d;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= e_reset;
            exp_pc_q <= '0;
            target_q <= '0;
            count_q  <= '0;
            since_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cmd_v_q  <= 1'b0;
            cmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_pc_q <= exp_pc_d;
            target_q <= target_d;
            count_q  <= count_d;
            since_q  <= since_d;
            done_q   <= done_d;
            error_q  <= error_d;
            cmd_v_q  <= cmd_v_d;
            cmd_q    <= cmd_d;
        end
    end

    assign fe_cmd_v_o    = cmd_v_q;
    assign fe_cmd_o      = cmd_q;
    assign instr_count_o = count_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_bp_fe_mock_be.sv
// Bench for bp_fe_mock_be: a randomized FE drives the queue and answers
// commands; a transaction-level model of the backend's rules predicts counts,
// flags and commands, and every comparison is an immediate assertion.
module tb_bp_fe_mock_be;
    import bp_fe_mock_be_pkg::*;

    localparam logic [38:0] BOOT = 39'h00_8000_0000;
    localparam int          INT  = 4;
    localparam logic [38:0] OFF  = 39'h40;
    localparam int          MAX  = 20;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    bp_fe_cmd_s   fe_cmd_o;
    logic         fe_cmd_v_o;
    logic         fe_cmd_yumi_i = 1'b0;
    bp_fe_queue_s fe_queue_i = '0;
    logic         fe_queue_v_i = 1'b0;
    logic         fe_queue_ready_o;
    logic [31:0]  instr_count_o;
    logic         done_o;
    logic         error_o;

    bp_fe_mock_be #(
        .boot_pc_p           (BOOT),
        .redirect_interval_p (INT),
        .redirect_offset_p   ('h40),
        .max_instr_p         (MAX),
        .stall_en_p          (1'b1)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .fe_cmd_o         (fe_cmd_o),
        .fe_cmd_v_o       (fe_cmd_v_o),
        .fe_cmd_yumi_i    (fe_cmd_yumi_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .instr_count_o    (instr_count_o),
        .done_o           (done_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    int npass = 0;
    int ntotal = 0;

    // Reference model: what the backend has promised so far
    bit          m_pend, m_squash, m_err, m_done, m_dead;
    bp_fe_cmd_s  m_cmd;
    logic [38:0] m_exp;
    int          m_cnt;

    // FE stimulus state
    logic [38:0] fe_pc, stale_pc;
    int fe_seq, stale_left, cmd_wait, cmd_delay;
    int bad_idx, exc_idx;
    bit stale_exc;
    int ready_seen, stall_seen;
    logic [38:0] first_redir;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset_i       = 1'b1;
        fe_cmd_yumi_i = 1'b0;
        fe_queue_v_i  = 1'b0;
        fe_queue_i    = '0;
        @(posedge clk_i); @(negedge clk_i);
        chk("rst_cmd_v", 64'(fe_cmd_v_o), 64'(0));
        chk("rst_cmd",   64'(fe_cmd_o), 64'(0));
        chk("rst_ready", 64'(fe_queue_ready_o), 64'(0));
        chk("rst_count", 64'(instr_count_o), 64'(0));
        chk("rst_done",  64'(done_o), 64'(0));
        chk("rst_error", 64'(error_o), 64'(0));
        @(posedge clk_i); @(negedge clk_i);
        reset_i = 1'b0;
        m_pend = 1; m_squash = 0; m_err = 0; m_done = 0; m_dead = 0;
        m_cmd = '0; m_cmd.opcode = e_op_state_reset; m_cmd.vaddr = BOOT;
        m_exp = '0; m_cnt = 0;
        fe_pc = '0; stale_pc = '0; fe_seq = 0; stale_left = 0;
        cmd_wait = 0; cmd_delay = $urandom_range(0, 3);
    endtask

    task automatic model_cmd();
        m_pend   = 0;
        m_squash = (m_cmd.opcode == e_op_pc_redirection);
        m_exp    = m_cmd.vaddr;
    endtask

    task automatic model_xfer(input bp_fe_queue_s p);
        if (m_squash && p.pc != m_exp) return;
        m_squash = 0;
        if (p.msg_type == e_fe_exception || p.pc != m_exp) begin
            m_err = 1; m_dead = 1;
        end else begin
            m_cnt++;
            m_exp = m_exp + 39'd4;
            if (m_cnt == MAX) begin
                m_done = 1; m_dead = 1;
            end else if (m_cnt % INT == 0) begin
                m_pend = 1;
                m_cmd = '0;
                m_cmd.opcode    = e_op_pc_redirection;
                m_cmd.subopcode = e_subop_branch_mispredict;
                m_cmd.vaddr     = m_exp + OFF;
            end
        end
    endtask

    // One clock: drive FE inputs, update model for the coming edge, check after it
    task automatic cycle();
        bp_fe_queue_s pkt;
        bit xfer, acc, was_stale;
        fe_cmd_yumi_i = fe_cmd_v_o && (cmd_wait >= cmd_delay);
        pkt = '0;
        was_stale = (stale_left > 0);
        if (was_stale) begin
            pkt.pc = stale_pc;
            if (stale_exc && stale_left == 1) pkt.msg_type = e_fe_exception;
        end else begin
            pkt.pc = fe_pc + ((fe_seq == bad_idx) ? 39'd4 : 39'd0);
            if (fe_seq == exc_idx) pkt.msg_type = e_fe_exception;
        end
        pkt.instr    = $urandom;
        fe_queue_i   = pkt;
        fe_queue_v_i = ($urandom_range(0, 3) != 0);

        xfer = fe_queue_v_i && fe_queue_ready_o;
        acc  = fe_cmd_v_o && fe_cmd_yumi_i;
        chk("rdy_gate", 64'(fe_queue_ready_o && (m_pend || m_dead)), 64'(0));
        if (!m_pend && !m_dead) begin
            if (fe_queue_ready_o) ready_seen++;
            else                  stall_seen++;
        end

        if (acc) model_cmd();
        if (xfer) model_xfer(pkt);

        if (acc) begin
            cmd_wait  = 0;
            cmd_delay = $urandom_range(0, 3);
            if (fe_cmd_o.opcode == e_op_pc_redirection) begin
                stale_left = $urandom_range(1, 3);
                stale_pc   = fe_pc;
                if (first_redir == '0) first_redir = fe_cmd_o.vaddr;
            end else begin
                stale_left = 0;
            end
            fe_pc = fe_cmd_o.vaddr;
        end else if (fe_cmd_v_o) begin
            cmd_wait++;
        end
        if (xfer) begin
            if (was_stale) begin
                stale_left--;
                stale_pc = stale_pc + 39'd4;
            end else begin
                fe_pc = fe_pc + 39'd4;
                fe_seq++;
            end
        end

        @(posedge clk_i); @(negedge clk_i);
        chk("count", 64'(instr_count_o), 64'(m_cnt));
        chk("done",  64'(done_o), 64'(m_done));
        chk("error", 64'(error_o), 64'(m_err));
        chk("cmd_v", 64'(fe_cmd_v_o), 64'(m_pend));
        if (m_pend) chk("cmd", 64'(fe_cmd_o), 64'(m_cmd));
    endtask

    task automatic run(input int limit);
        for (int c = 0; c < limit && !m_dead; c++) cycle();
        chk("run_ended", 64'(done_o || error_o), 64'(1));
        repeat (3) cycle();
    endtask

    initial begin
        ready_seen = 0; stall_seen = 0; first_redir = '0;

        // Full run with redirects, stale exceptions dropped during squash
        bad_idx = -1; exc_idx = -1; stale_exc = 1;
        do_reset();
        run(3000);
        chk("a_done",   64'(done_o), 64'(1));
        chk("a_error",  64'(error_o), 64'(0));
        chk("a_count",  64'(instr_count_o), 64'(MAX));
        chk("a_ready",  64'(fe_queue_ready_o), 64'(0));
        chk("a_redir",  64'(first_redir), 64'(39'h00_8000_0050));
        chk("a_stalls", 64'(stall_seen > 0), 64'(1));
        chk("a_readys", 64'(ready_seen > 0), 64'(1));

        // Reset while the boot command is pending restarts the sequence
        do_reset();
        cmd_delay = 100;
        cycle();
        cycle();
        chk("mid_cmd_v", 64'(fe_cmd_v_o), 64'(1));
        do_reset();

        // Third packet skips ahead by 4
        bad_idx = 2; stale_exc = 0;
        run(1000);
        chk("b_error", 64'(error_o), 64'(1));
        chk("b_count", 64'(instr_count_o), 64'(2));
        chk("b_done",  64'(done_o), 64'(0));
        chk("b_ready", 64'(fe_queue_ready_o), 64'(0));

        // Exception in run after a squash that dropped a stale exception
        bad_idx = -1; exc_idx = 6; stale_exc = 1;
        do_reset();
        run(1000);
        chk("c_error", 64'(error_o), 64'(1));
        chk("c_count", 64'(instr_count_o), 64'(6));
        chk("c_cmd_v", 64'(fe_cmd_v_o), 64'(0));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
